// File: rtl/alu_ctrl_exec.sv
// EX-stage ALU: ALUOp/funct decode, single-cycle logic/arith ops, iterative multu.
// Optional restoring divu unit is built when ALU_DIVU_EN is defined.
module alu_ctrl_exec #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [5:0]         funct,
  input  logic [DATA_W-1:0]  src_a,
  input  logic [DATA_W-1:0]  src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic [DATA_W-1:0]  hi,
  output logic               zero,
  output logic [3:0]         alu_code
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [3:0] C_AND   = 4'b0000;
  localparam logic [3:0] C_OR    = 4'b0001;
  localparam logic [3:0] C_ADD   = 4'b0010;
  localparam logic [3:0] C_SUB   = 4'b0110;
  localparam logic [3:0] C_SLT   = 4'b0111;
  localparam logic [3:0] C_NOR   = 4'b1100;
  localparam logic [3:0] C_MULTU = 4'b1000;
`ifdef ALU_DIVU_EN
  localparam logic [3:0] C_DIVU  = 4'b1001;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef ALU_DIVU_EN
    S_DIV  = 2'd2,
`endif
    S_HOLD = 2'd3
  } state_t;

  state_t state, state_nx, op_nx;

  logic [3:0]        code;
  logic [DATA_W-1:0] alu_res;
  logic              accept;
  logic              last;

  // iterative datapath: acc_hi:acc_lo is product (mul) or remainder:quotient (div)
  logic [DATA_W-1:0] acc_hi, acc_lo, opnd;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] mul_hi, mul_lo;

  always_comb begin
    code = C_ADD;
    case (alu_op)
      ALUOP_W'(3'b000): code = C_ADD;
      ALUOP_W'(3'b001): code = C_SUB;
      ALUOP_W'(3'b011): code = C_ADD;
      ALUOP_W'(3'b100): code = C_AND;
      ALUOP_W'(3'b010): begin
        case (funct)
          6'b100000: code = C_ADD;
          6'b100010: code = C_SUB;
          6'b100100: code = C_AND;
          6'b100101: code = C_OR;
          6'b101010: code = C_SLT;
          6'b100111: code = C_NOR;
          6'b011001: code = C_MULTU;
`ifdef ALU_DIVU_EN
          6'b011011: code = C_DIVU;
`endif
          default:   code = C_ADD;
        endcase
      end
      default: code = C_ADD;
    endcase
  end

  always_comb begin
    alu_res = src_a + src_b;
    case (code)
      C_SUB:   alu_res = src_a - src_b;
      C_AND:   alu_res = src_a & src_b;
      C_OR:    alu_res = src_a | src_b;
      C_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      C_NOR:   alu_res = ~(src_a | src_b);
      default: alu_res = src_a + src_b;
    endcase
  end

  // shift-add step: conditionally add multiplicand, then shift {carry,hi,lo} right
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_hi  = mul_sum[DATA_W:1];
  assign mul_lo  = {mul_sum[0], acc_lo[DATA_W-1:1]};

`ifdef ALU_DIVU_EN
  // restoring step; the extra guard bit keeps divide-by-zero borrow-free,
  // which yields quotient all ones and remainder = dividend on its own
  logic [DATA_W:0]   div_shift;
  logic [DATA_W+1:0] div_diff;
  logic              div_borrow;
  logic [DATA_W-1:0] div_rem, div_quo;

  assign div_shift  = {acc_hi, acc_lo[DATA_W-1]};
  assign div_diff   = {1'b0, div_shift} - {2'b00, opnd};
  assign div_borrow = div_diff[DATA_W+1];
  assign div_rem    = div_borrow ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
  assign div_quo    = {acc_lo[DATA_W-2:0], ~div_borrow};
`endif

  assign in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
  assign out_valid = (state == S_HOLD);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    op_nx = S_HOLD;
    if (code == C_MULTU) op_nx = S_MUL;
`ifdef ALU_DIVU_EN
    if (code == C_DIVU)  op_nx = S_DIV;
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = op_nx;
      S_MUL:  if (last) state_nx = S_HOLD;
`ifdef ALU_DIVU_EN
      S_DIV:  if (last) state_nx = S_HOLD;
`endif
      S_HOLD: begin
        if (accept)         state_nx = op_nx;
        else if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      result   <= '0;
      hi       <= '0;
      zero     <= 1'b0;
      alu_code <= 4'b0000;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      cnt      <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        alu_code <= code;
        cnt      <= '0;
        if (op_nx == S_HOLD) begin
          result <= alu_res;
          hi     <= '0;
          zero   <= (alu_res == '0);
        end else begin
          acc_hi <= '0;
`ifdef ALU_DIVU_EN
          acc_lo <= (op_nx == S_DIV) ? src_a : src_b;
          opnd   <= (op_nx == S_DIV) ? src_b : src_a;
`else
          acc_lo <= src_b;
          opnd   <= src_a;
`endif
        end
      end else if (state == S_MUL) begin
        acc_hi <= mul_hi;
        acc_lo <= mul_lo;
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          result <= mul_lo;
          hi     <= mul_hi;
          zero   <= (mul_lo == '0);
        end
      end
`ifdef ALU_DIVU_EN
      else if (state == S_DIV) begin
        acc_hi <= div_rem;
        acc_lo <= div_quo;
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          result <= div_quo;
          hi     <= div_rem;
          zero   <= (div_quo == '0);
        end
      end
`endif
    end
  end

endmodule
